open_word_scanner: RTL and testbench
====================================

# open_word_scanner

Multiplexed scan sequencer for the 4-digit seven-segment display. Generates the 4-bit letter code and the active-low digit anode select for each time slot, spelling "OPEN" either statically or as a right-to-left scrolling message. Its `data` output feeds the seven-segment letter decoder directly, so one decoder is time-shared across all four digits.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit is lit, min 2. At 50 MHz this gives a 1 kHz digit rate.
- `SCROLL_FRAMES`, 125: full 4-digit frames per scroll step, min 1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request to begin display.
- `stop`  in  1  one-cycle request to blank and halt.
- `scroll_en`  in  1  level: 1 = scroll, 0 = static; sampled at start and at frame boundaries.
- `data`  out  4  letter code to the decoder. Codes: 0=O, 1=P, 2=E, 3=N, 4'hF=blank.
- `digit_an`  out  4  active-low anode select; bit i = digit i, digit 0 leftmost.
- `frame_tick`  out  1  one-cycle pulse at each frame start after the first.

## Operation
- States:
  - BLANK: halted.
  - SHOW: static "OPEN", offset held at 0.
  - SCROLL: offset advances.
- Counters:
  - prescaler `pre`: 0..REFRESH_DIV-1.
  - digit index `idx`: 0..3.
  - frame counter `frm`: 0..SCROLL_FRAMES-1.
  - `offset`: 0..7.
- Message: 8 positions, p<4 → code p, p≥4 → 4'hF. The code for digit i is msg[(offset+i) mod 8].
- BLANK:
  - data=4'hF, digit_an=4'b1111, all counters 0.
  - `start` moves to SCROLL if scroll_en=1, else to SHOW.
- SHOW/SCROLL:
  - `pre` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances.
  - On the edge where `idx` wraps 3→0 (frame boundary):
    - frame_tick=1 for one cycle, coincident with digit 0 being driven.
    - scroll_en re-sampled: 1 → SCROLL, 0 → SHOW with offset←0, frm←0.
    - In SCROLL, `frm` increments. When it wraps from SCROLL_FRAMES-1, offset←(offset+1) mod 8, effective for the new frame's digit 0.
  - `start` while running: ignored.
  - `stop`: next cycle BLANK, outputs blanked, all counters 0.
- Priority: rst > stop > start. `stop` and `start` in the same cycle → BLANK.
- Offset wraps 7→0 seamlessly with no blank frame inserted.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: data=4'hF, digit_an=4'b1111, frame_tick=0, state BLANK, all counters 0.
- Start latency is 1 cycle. In the cycle after `start` is sampled: digit_an=4'b1110, data=msg[offset].
- Each digit is driven for exactly REFRESH_DIV cycles. A frame lasts 4·REFRESH_DIV cycles; a scroll step lasts 4·REFRESH_DIV·SCROLL_FRAMES cycles.
- digit_an has exactly one bit low in SHOW/SCROLL. data and digit_an change on the same edge.
- Reset mid-operation restores reset values on the next edge regardless of state.

## Structure
- Shared package `open_disp_pkg`:
  - code constants CODE_O/P/E/N=4'h0..4'h3, CODE_BLANK=4'hF.
  - state enum {BLANK, SHOW, SCROLL}.
  - MSG_LEN=8.
  - The decoder imports the same package.
- Counter widths: $clog2(REFRESH_DIV) and $clog2(SCROLL_FRAMES), each with a minimum of 1 bit.
- One sub-module, `disp_tick_gen`:
  - the REFRESH_DIV prescaler with a synchronous clear.
  - outputs a one-cycle tick at terminal count.

## Test plan
Benches use REFRESH_DIV=4, SCROLL_FRAMES=2 unless noted.
- Reset idle: hold 10 cycles with no start → data=4'hF, digit_an=4'b1111, frame_tick=0 every cycle.
- Static: start with scroll_en=0 → next cycle 1110/0.
  - Every 4 cycles: 1101/1, 1011/2, 0111/3.
  - Then 1110/0 with frame_tick=1, repeating unchanged for 5 frames.
- Scroll sweep: start with scroll_en=1.
  - Frames 1–2 show codes 0,1,2,3.
  - Frames 3–4 show 1,2,3,F.
  - Offset 4 shows F,F,F,F.
  - Offset 7 shows F,0,1,2.
  - The following frame returns to 0,1,2,3.
- Mode change mid-frame: toggle scroll_en 1→0 during digit 2 at offset 3.
  - No change until the frame boundary.
  - Then SHOW with offset 0: codes 0,1,2,3.
- Stop/start collision: assert start and stop together during digit 1 → next cycle blank, counters 0. A later start resumes at 1110/0 with offset 0.
- Reset mid-scroll: assert rst at offset 5, digit 2 → next cycle reset values. Outputs stay blank until a fresh start.

Source files
------------

// File: rtl/open_disp_pkg.sv
// Shared definitions for the "OPEN" seven-segment display path.
// Used by the scan sequencer and by the letter decoder it feeds.
package open_disp_pkg;

    // Letter codes understood by the seven-segment letter decoder.
    localparam logic [3:0] CODE_O     = 4'h0;
    localparam logic [3:0] CODE_P     = 4'h1;
    localparam logic [3:0] CODE_E     = 4'h2;
    localparam logic [3:0] CODE_N     = 4'h3;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // The scrolled message is "OPEN" followed by four blank positions.
    localparam int MSG_LEN = 8;

    // Scan sequencer operating states.
    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SHOW   = 2'd1,
        SCROLL = 2'd2
    } state_t;

    // Letter code at message position pos: positions 0..3 spell O,P,E,N
    // (codes 0..3), positions 4..7 are blank.
    function automatic logic [3:0] msg_code(input logic [2:0] pos);
        logic [3:0] code;
        if (pos[2]) begin
            code = CODE_BLANK;
        end else begin
            code = {2'b00, pos[1:0]};
        end
        return code;
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Refresh prescaler: counts enabled cycles 0..REFRESH_DIV-1 and flags the
// terminal count so the sequencer can step to the next digit.
module disp_tick_gen
    import open_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int              PRE_W    = cnt_width(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_at_last;

    assign w_at_last = (r_pre == PRE_LAST);

    // Prescaler count; clear holds it at zero while the display is halted.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_pre <= '0;
        end else if (i_en) begin
            if (w_at_last) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    // Tick is high during the last cycle of each digit slot.
    always_comb begin
        o_tick = i_en && w_at_last;
    end

endmodule

// File: rtl/open_word_scanner.sv
// Multiplexed scan sequencer for a 4-digit seven-segment display spelling
// "OPEN", either static or scrolling right-to-left. One letter decoder is
// time-shared across all digits through o_data; o_digit_an picks the digit.
//
// i_start and i_stop are single-cycle requests with no handshake: they are
// acted on in the cycle they are sampled high, stop beats start, and start
// is ignored while the display is already running. i_scroll_en is a level
// sampled at start and at every frame boundary.
module open_word_scanner
    import open_disp_pkg::*;
#(
    parameter int REFRESH_DIV   = 50000,
    parameter int SCROLL_FRAMES = 125
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_scroll_en,
    output logic [3:0] o_data,
    output logic [3:0] o_digit_an,
    output logic       o_frame_tick,
    output state_t     o_dbg_state
);

    localparam int               FRM_W    = cnt_width(SCROLL_FRAMES);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(SCROLL_FRAMES - 1);

    // Registered state and counters.
    state_t           r_state;
    logic [1:0]       r_idx;
    logic [FRM_W-1:0] r_frm;
    logic [2:0]       r_offset;

    // Registered outputs.
    logic [3:0]       r_data;
    logic [3:0]       r_an;
    logic             r_frame_tick;

    // Next-state values.
    state_t           w_state_n;
    logic [1:0]       w_idx_n;
    logic [FRM_W-1:0] w_frm_n;
    logic [2:0]       w_offset_n;
    logic [3:0]       w_data_n;
    logic [3:0]       w_an_n;
    logic             w_frame_tick_n;

    // Prescaler control.
    logic             w_running;
    logic             w_pre_clr;
    logic             w_tick;
    logic [2:0]       w_pos_n;

    assign w_running = (r_state != BLANK);
    assign w_pre_clr = (r_state == BLANK) || i_stop;

    disp_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_pre_clr),
        .i_en   (w_running),
        .o_tick (w_tick)
    );

    // State, counter and output registers; reset returns to a blank halt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= BLANK;
            r_idx        <= 2'd0;
            r_frm        <= '0;
            r_offset     <= 3'd0;
            r_data       <= CODE_BLANK;
            r_an         <= 4'b1111;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_idx        <= w_idx_n;
            r_frm        <= w_frm_n;
            r_offset     <= w_offset_n;
            r_data       <= w_data_n;
            r_an         <= w_an_n;
            r_frame_tick <= w_frame_tick_n;
        end
    end

    // Next state, digit/frame/offset stepping, and the outputs for the next
    // cycle derived from the next counters so data and anode move together.
    always_comb begin
        w_state_n      = r_state;
        w_idx_n        = r_idx;
        w_frm_n        = r_frm;
        w_offset_n     = r_offset;
        w_frame_tick_n = 1'b0;

        if (i_stop) begin
            w_state_n  = BLANK;
            w_idx_n    = 2'd0;
            w_frm_n    = '0;
            w_offset_n = 3'd0;
        end else if (r_state == BLANK) begin
            w_idx_n    = 2'd0;
            w_frm_n    = '0;
            w_offset_n = 3'd0;
            if (i_start) begin
                w_state_n = i_scroll_en ? SCROLL : SHOW;
            end
        end else if (w_tick) begin
            w_idx_n = r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                // Frame boundary: new frame starts on digit 0.
                w_frame_tick_n = 1'b1;
                if (i_scroll_en) begin
                    w_state_n = SCROLL;
                    // Only frames spent scrolling count toward a step, so a
                    // switch from SHOW starts the step count afresh.
                    if (r_state == SCROLL) begin
                        if (r_frm == FRM_LAST) begin
                            w_frm_n    = '0;
                            w_offset_n = r_offset + 3'd1;
                        end else begin
                            w_frm_n = r_frm + 1'b1;
                        end
                    end
                end else begin
                    w_state_n  = SHOW;
                    w_frm_n    = '0;
                    w_offset_n = 3'd0;
                end
            end
        end

        // Message position for the digit about to be lit; wraps mod 8.
        w_pos_n  = w_offset_n + {1'b0, w_idx_n};
        w_data_n = CODE_BLANK;
        w_an_n   = 4'b1111;
        if (w_state_n != BLANK) begin
            w_data_n = msg_code(w_pos_n);
            w_an_n   = ~(4'b0001 << w_idx_n);
        end
    end

    assign o_data       = r_data;
    assign o_digit_an   = r_an;
    assign o_frame_tick = r_frame_tick;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_open_word_scanner.sv
// Directed bench for open_word_scanner with REFRESH_DIV=4, SCROLL_FRAMES=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_open_word_scanner;
    import open_disp_pkg::*;

    localparam int DIV = 4;
    localparam int SF  = 2;

    // Expected digit0..digit3 codes (digit 0 in the top nibble) per offset.
    localparam logic [15:0] EXP_TAB [8] = '{
        16'h0123, 16'h123F, 16'h23FF, 16'h3FFF,
        16'hFFFF, 16'hFFF0, 16'hFF01, 16'hF012
    };

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       scroll_en;
    logic [3:0] data;
    logic [3:0] digit_an;
    logic       frame_tick;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    open_word_scanner #(
        .REFRESH_DIV   (DIV),
        .SCROLL_FRAMES (SF)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_scroll_en  (scroll_en),
        .o_data       (data),
        .o_digit_an   (digit_an),
        .o_frame_tick (frame_tick),
        .o_dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle to the sampling point.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_data,
                       input logic [3:0] e_an, input logic e_ft);
        n_checks++;
        assert ({data, digit_an, frame_tick} === {e_data, e_an, e_ft}) else begin
            n_fail++;
            $error("FAIL %s: data/an/tick got %h/%b/%b expected %h/%b/%b",
                   tag, data, digit_an, frame_tick, e_data, e_an, e_ft);
        end
    endtask

    task automatic chk_state(input string tag, input state_t e_st);
        n_checks++;
        assert (dbg_state === e_st) else begin
            n_fail++;
            $error("FAIL %s: state got %0d expected %0d", tag, dbg_state, e_st);
        end
    endtask

    // Check a blank halted display for n consecutive cycles.
    task automatic chk_blank(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 4'hF, 4'b1111, 1'b0);
            adv(1);
        end
    endtask

    // Check digits d_from..d_to of a frame, DIV cycles each, starting at
    // the first cycle of d_from; leaves the sample point after the span.
    task automatic chk_span(input string tag, input logic [15:0] codes,
                            input logic ft_first, input int d_from, input int d_to);
        logic [3:0] e_an;
        logic [3:0] e_code;
        logic       e_ft;
        for (int d = d_from; d <= d_to; d++) begin
            e_an   = ~(4'b0001 << d);
            e_code = codes[(3-d)*4 +: 4];
            for (int k = 0; k < DIV; k++) begin
                e_ft = (d == 0 && k == 0) ? ft_first : 1'b0;
                chk(tag, e_code, e_an, e_ft);
                adv(1);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        scroll_en = 1'b0;
        adv(3);

        // Reset values and idle with no start.
        chk("reset_vals", 4'hF, 4'b1111, 1'b0);
        chk_state("reset_state", BLANK);
        rst = 1'b0;
        adv(1);
        chk_blank("idle", 10);
        chk_state("idle_state", BLANK);

        // Static display.
        scroll_en = 1'b0;
        start     = 1'b1;
        adv(1);
        start = 1'b0;
        chk_state("static_state", SHOW);
        chk_span("static_f0", 16'h0123, 1'b0, 0, 3);
        for (int f = 1; f < 5; f++) chk_span("static_fn", 16'h0123, 1'b1, 0, 3);
        // Start held during a running frame is ignored.
        chk_span("run_start_a", 16'h0123, 1'b1, 0, 1);
        start = 1'b1;
        chk_span("run_start_b", 16'h0123, 1'b0, 2, 2);
        start = 1'b0;
        chk_span("run_start_c", 16'h0123, 1'b0, 3, 3);

        // Halt, then scroll sweep through all eight offsets and wrap.
        stop = 1'b1;
        adv(1);
        stop = 1'b0;
        chk_blank("stop_blank", 2);
        scroll_en = 1'b1;
        start     = 1'b1;
        adv(1);
        start = 1'b0;
        chk_state("scroll_state", SCROLL);
        for (int off = 0; off < 8; off++) begin
            for (int rep = 0; rep < SF; rep++) begin
                chk_span("sweep", EXP_TAB[off], !(off == 0 && rep == 0), 0, 3);
            end
        end
        chk_span("sweep_wrap", EXP_TAB[0], 1'b1, 0, 3);

        // Mode change during digit 2 at offset 3: effective at the boundary.
        chk_span("to_off3", EXP_TAB[0], 1'b1, 0, 3);
        for (int off = 1; off < 3; off++) begin
            for (int rep = 0; rep < SF; rep++) chk_span("to_off3", EXP_TAB[off], 1'b1, 0, 3);
        end
        chk_span("mode_pre", EXP_TAB[3], 1'b1, 0, 1);
        scroll_en = 1'b0;
        chk_span("mode_hold", EXP_TAB[3], 1'b0, 2, 3);
        chk_state("mode_show_state", SHOW);
        chk_span("mode_show", 16'h0123, 1'b1, 0, 3);
        chk_span("mode_show2", 16'h0123, 1'b1, 0, 3);

        // Start and stop together during digit 1: stop wins.
        chk_span("coll_pre", 16'h0123, 1'b1, 0, 0);
        start = 1'b1;
        stop  = 1'b1;
        adv(1);
        start = 1'b0;
        stop  = 1'b0;
        chk_state("coll_state", BLANK);
        chk_blank("coll_blank", 3);
        scroll_en = 1'b1;
        start     = 1'b1;
        adv(1);
        start = 1'b0;
        chk_span("coll_resume", EXP_TAB[0], 1'b0, 0, 3);
        chk_span("coll_resume2", EXP_TAB[0], 1'b1, 0, 3);
        chk_span("coll_resume3", EXP_TAB[1], 1'b1, 0, 3);

        // Reset mid-scroll at offset 5, digit 2.
        chk_span("to_off5", EXP_TAB[1], 1'b1, 0, 3);
        for (int off = 2; off < 5; off++) begin
            for (int rep = 0; rep < SF; rep++) chk_span("to_off5", EXP_TAB[off], 1'b1, 0, 3);
        end
        chk_span("rst_pre", EXP_TAB[5], 1'b1, 0, 1);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        chk_state("rst_state", BLANK);
        chk_blank("rst_blank", 12);
        chk_state("rst_state_hold", BLANK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, limit 200000 reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
